// File: rtl/gate_ctrl.sv
// rtl/gate_ctrl.sv - measurement gate sequencer: CLEAR -> GATE -> HOLD -> LATCH with range select
module gate_ctrl #(
  parameter int GATE0  = 50_000_000,
  parameter int GATE1  = 5_000_000,
  parameter int GATE2  = 500_000,
  parameter int GATE3  = 50_000,
  parameter int SETTLE = 4,
  parameter int CW     = 26
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RUN,
  input  logic [1:0] RANGE,
  output logic       D,
  output logic       CNT_CLR,
  output logic       LATCH,
  output logic       BUSY,
  output logic [1:0] RANGE_Q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_HOLD,
    S_LATCH
  } state_t;

  localparam logic [CW-1:0] GATE0_M1  = CW'(GATE0 - 1);
  localparam logic [CW-1:0] GATE1_M1  = CW'(GATE1 - 1);
  localparam logic [CW-1:0] GATE2_M1  = CW'(GATE2 - 1);
  localparam logic [CW-1:0] GATE3_M1  = CW'(GATE3 - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    rng, rng_nx;
  logic [CW-1:0] gate_m1;

  // gate length comes from the range captured at the start edge, never the live input
  always_comb begin
    gate_m1 = GATE0_M1;
    case (rng)
      2'd0:    gate_m1 = GATE0_M1;
      2'd1:    gate_m1 = GATE1_M1;
      2'd2:    gate_m1 = GATE2_M1;
      default: gate_m1 = GATE3_M1;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rng_nx   = rng;
    case (state)
      S_IDLE: begin
        if (RUN) begin
          state_nx = S_CLEAR;
          rng_nx   = RANGE;
        end
      end
      S_CLEAR: begin
        state_nx = S_GATE;
        cnt_nx   = gate_m1;
      end
      S_GATE: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = SETTLE_M1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_LATCH;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_LATCH: begin
        if (RUN) begin
          state_nx = S_CLEAR;
          rng_nx   = RANGE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs are flopped from the next-state decode so they line up with the state register
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rng     <= 2'd0;
      D       <= 1'b0;
      CNT_CLR <= 1'b0;
      LATCH   <= 1'b0;
      BUSY    <= 1'b0;
      RANGE_Q <= 2'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rng     <= rng_nx;
      D       <= (state_nx == S_GATE);
      CNT_CLR <= (state_nx == S_CLEAR);
      LATCH   <= (state_nx == S_LATCH);
      BUSY    <= (state_nx != S_IDLE);
      if (state_nx == S_LATCH && state != S_LATCH) begin
        RANGE_Q <= rng_nx;
      end
    end
  end

endmodule

// File: doc/gate_ctrl.md
GATE_CTRL -- requirements
Module: gate_ctrl

Interface
REQ-001 The block SHALL have parameter GATE0, default 50_000_000, meaning gate length in CLK cycles for RANGE=0 (1 s at 50 MHz).
REQ-002 The block SHALL have parameter GATE1, default 5_000_000, meaning gate length in CLK cycles for RANGE=1.
REQ-003 The block SHALL have parameter GATE2, default 500_000, meaning gate length in CLK cycles for RANGE=2.
REQ-004 The block SHALL have parameter GATE3, default 50_000, meaning gate length in CLK cycles for RANGE=3.
REQ-005 The block SHALL have parameter SETTLE, default 4, meaning post-gate wait in CLK cycles before LATCH.
REQ-006 The block SHALL have parameter CW, default 26, meaning the width of the internal cycle counter.
REQ-007 The block SHALL have one clock and an asynchronous active-high reset, as the ports listed below.
REQ-008 CLK  input  1  clock; all state SHALL change on its rising edge.
REQ-009 CLR  input  1  asynchronous, active-high reset.
REQ-010 RUN  input  1  level-sensitive measurement request; held high, it SHALL produce continuous back-to-back measurements.
REQ-011 RANGE  input  2  gate-length select (0..3 selects GATE0..GATE3).
REQ-012 D  output  1  gate request to the count-enable flip-flop; high for exactly one gate window.
REQ-013 CNT_CLR  output  1  one-cycle pulse that clears the measurement counter.
REQ-014 LATCH  output  1  one-cycle pulse that loads the counter value into the display register.
REQ-015 BUSY  output  1  high in every state except IDLE.
REQ-016 RANGE_Q  output  2  range used by the most recently latched measurement.

Function
REQ-017 The block SHALL implement states IDLE, CLEAR, GATE, HOLD and LATCH, with all outputs registered and decoded from the state.
REQ-018 In IDLE with RUN=1 at a rising edge, the next state SHALL be CLEAR, and RANGE SHALL be captured into an internal range register at that edge.
REQ-019 CLEAR SHALL last exactly 1 cycle with CNT_CLR=1, then go to GATE with the cycle counter loaded to the selected GATEx-1.
REQ-020 GATE SHALL hold D=1 for exactly GATEx cycles (counter decrements to 0), then go to HOLD with the counter loaded to SETTLE-1.
REQ-021 HOLD SHALL hold D=0 for exactly SETTLE cycles, then go to LATCH.
REQ-022 LATCH SHALL last exactly 1 cycle with LATCH=1; RANGE_Q SHALL take the captured range on entry to LATCH.
REQ-023 From LATCH, if RUN=1 the next state SHALL be CLEAR (with RANGE recaptured at that edge); otherwise it SHALL be IDLE.
REQ-024 The measurement period under continuous RUN SHALL be exactly 1+GATEx+SETTLE+1 cycles.
REQ-025 A change of RANGE outside the capture edges SHALL NOT affect the measurement in progress.
REQ-026 RUN falling in CLEAR, GATE or HOLD SHALL NOT abort the measurement; the sequence SHALL complete through LATCH, then enter IDLE.
REQ-027 D, CNT_CLR and LATCH SHALL be mutually exclusive in every cycle.
REQ-028 Parameter rules: each GATEx SHALL be in 1..2^CW-1, and SETTLE SHALL be in 1..2^CW-1; the counter SHALL never wrap.

Reset
REQ-029 While CLR=1, the block SHALL hold state=IDLE, D=0, CNT_CLR=0, LATCH=0, BUSY=0, RANGE_Q=0, and counter=0, regardless of CLK.
REQ-030 CLR asserted mid-operation SHALL force D low immediately (asynchronously), with no LATCH pulse for the aborted measurement.
REQ-031 After CLR deasserts, the first possible CLEAR SHALL occur at the first rising edge with RUN=1.

Verification
All scenarios use GATE0=20, GATE1=10, GATE2=5, GATE3=2, SETTLE=3.
REQ-032 Reset: CLR=1, then release with RUN=0 -> all outputs stay 0, BUSY=0 indefinitely.
REQ-033 Single shot: RANGE=2, RUN high for 1 cycle -> CNT_CLR 1 cycle; D high exactly 5 cycles; 3 low cycles; LATCH 1 cycle; RANGE_Q=2; BUSY low afterwards.
REQ-034 Continuous: RUN=1, RANGE=3 -> LATCH every 7 cycles; D high 2 cycles per period; D/CNT_CLR/LATCH never overlap.
REQ-035 Range change: RANGE=0, then 1 during GATE -> current D window is 20 cycles with RANGE_Q=0 at its LATCH; next D window is 10 cycles with RANGE_Q=1.
REQ-036 Abort: CLR pulsed at cycle 8 of the GATE0 window -> D drops before the next edge, no LATCH; after release with RUN=1, a fresh CNT_CLR precedes a full 20-cycle D window.
REQ-037 RUN drop: RUN falls mid-GATE -> gate completes at full length, LATCH fires once, then IDLE with BUSY=0.
